// File: rtl/controlador_display_producto.sv
// controlador_display_producto: signed product to sign+BCD via double dabble, multiplexed onto a 7-segment display
module controlador_display_producto #(
  parameter int ANODO_ACTIVO_BAJO = 1,
  parameter int SEG_ACTIVO_BAJO   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] producto,
  input  logic        producto_valido,
  input  logic [2:0]  contador_actualizar,
  output logic        ocupado,
  output logic        listo,
  output logic [7:0]  anodos,
  output logic [6:0]  segmentos,
  output logic        punto
);
  typedef enum logic [1:0] {REPOSO, DESPLAZA, ACTUALIZA} estado_t;
  localparam logic [7:0] AN_OFF  = (ANODO_ACTIVO_BAJO != 0) ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVO_BAJO != 0) ? 7'h7F : 7'h00;
  estado_t     state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mag_q, mag_d;
  logic [19:0] scr_q, scr_d, adj;
  logic        sgn_cap_q, sgn_cap_d;
  logic [19:0] digits_q, digits_d;
  logic        sign_q, sign_d;
  logic        listo_q, listo_d;
  logic [7:0]  anodos_q, anodos_d, an_ah;
  logic [6:0]  segmentos_q, segmentos_d, seg_ah, code;
  logic [19:0] sh;
  // State and display registers; reset clears the shown value to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= REPOSO;
      cnt_q       <= '0;
      mag_q       <= '0;
      scr_q       <= '0;
      sgn_cap_q   <= 1'b0;
      digits_q    <= '0;
      sign_q      <= 1'b0;
      listo_q     <= 1'b0;
      anodos_q    <= AN_OFF;
      segmentos_q <= SEG_OFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      scr_q       <= scr_d;
      sgn_cap_q   <= sgn_cap_d;
      digits_q    <= digits_d;
      sign_q      <= sign_d;
      listo_q     <= listo_d;
      anodos_q    <= anodos_d;
      segmentos_q <= segmentos_d;
    end
  end
  // Conversion FSM: capture |producto|, 16 add-3/shift steps, then publish digits
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    scr_d     = scr_q;
    sgn_cap_d = sgn_cap_q;
    digits_d  = digits_q;
    sign_d    = sign_q;
    listo_d   = 1'b0;
    adj       = scr_q;
    for (int i = 0; i < 5; i++)
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    case (state_q)
      REPOSO: if (producto_valido) begin
        sgn_cap_d = producto[15];
        mag_d     = producto[15] ? ~producto + 16'd1 : producto;
        scr_d     = '0;
        cnt_d     = '0;
        state_d   = DESPLAZA;
      end
      DESPLAZA: begin
        scr_d   = 20'({adj, mag_q[15]});
        mag_d   = {mag_q[14:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd15) ? ACTUALIZA : DESPLAZA;
      end
      ACTUALIZA: begin
        digits_d = scr_q;
        sign_d   = sgn_cap_q;
        listo_d  = 1'b1;
        state_d  = REPOSO;
      end
      default: state_d = REPOSO;
    endcase
  end
  // Digit selection, leading-zero blanking and segment encoding for the next refresh slot
  always_comb begin
    sh = digits_q >> {contador_actualizar, 2'b00};
    case (sh[3:0])
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h00;
    endcase
    an_ah  = (contador_actualizar > 3'd5) ? 8'h00 : 8'h01 << contador_actualizar;
    seg_ah = (contador_actualizar > 3'd5) ? 7'h00 :
             (contador_actualizar == 3'd5) ? (sign_q ? 7'h40 : 7'h00) :
             (contador_actualizar != 3'd0 && sh == 20'd0) ? 7'h00 : code;
    anodos_d    = (ANODO_ACTIVO_BAJO != 0) ? ~an_ah : an_ah;
    segmentos_d = (SEG_ACTIVO_BAJO != 0) ? ~seg_ah : seg_ah;
  end
  assign ocupado   = state_q != REPOSO;
  assign listo     = listo_q;
  assign anodos    = anodos_q;
  assign segmentos = segmentos_q;
  assign punto     = SEG_ACTIVO_BAJO != 0;
endmodule

// File: tb/tb_controlador_display_producto.sv
// tb_controlador_display_producto: randomized check of conversion timing and display against a decimal model
module tb_controlador_display_producto;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] producto;
  logic        producto_valido;
  logic [2:0]  contador_actualizar;
  logic        ocupado, listo, punto;
  logic [7:0]  anodos;
  logic [6:0]  segmentos;
  int checks = 0, errors = 0, shown = 0;
  controlador_display_producto dut (
    .clk(clk), .reset(reset), .producto(producto), .producto_valido(producto_valido),
    .contador_actualizar(contador_actualizar), .ocupado(ocupado), .listo(listo),
    .anodos(anodos), .segmentos(segmentos), .punto(punto)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction
  function automatic logic [6:0] exp_seg(input int v, input int k);
    int m, p10;
    logic [6:0] s;
    m = v < 0 ? -v : v;
    p10 = 1;
    for (int i = 0; i < k && i < 5; i++) p10 *= 10;
    if (k > 5) s = 7'h00;
    else if (k == 5) s = v < 0 ? 7'h40 : 7'h00;
    else if (k > 0 && m < p10) s = 7'h00;
    else s = digit_code((m / p10) % 10);
    return ~s;
  endfunction
  function automatic logic [7:0] exp_an(input int k);
    logic [7:0] one = 8'h01;
    return k > 5 ? 8'hFF : ~(one << k);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input int v);
    for (int k = 0; k < 8; k++) begin
      contador_actualizar = 3'(k);
      step();
      chk($sformatf("an%0d", k), anodos, exp_an(k));
      chk($sformatf("seg%0d v=%0d", k, v), segmentos, exp_seg(v, k));
    end
    chk("punto", punto, 1);
  endtask
  task automatic convert(input logic [15:0] p);
    int k;
    k = $urandom_range(0, 5);
    contador_actualizar = 3'(k);
    producto = p;
    producto_valido = 1'b1;
    step();
    producto_valido = 1'b0;
    producto = 16'($urandom);
    chk("ocupado_start", ocupado, 1);
    chk("hold0", segmentos, exp_seg(shown, k));
    for (int c = 1; c <= 17; c++) begin
      step();
      chk($sformatf("ocupado c%0d", c), ocupado, c <= 16);
      chk($sformatf("listo c%0d", c), listo, c == 17);
      chk($sformatf("hold c%0d", c), segmentos, exp_seg(shown, k));
    end
    shown = int'($signed(p));
  endtask
  initial begin
    int n;
    reset = 1'b1;
    producto = '0;
    producto_valido = 1'b0;
    contador_actualizar = '0;
    step();
    step();
    chk("rst_an", anodos, 8'hFF);
    chk("rst_seg", segmentos, 7'h7F);
    chk("rst_punto", punto, 1);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_listo", listo, 0);
    reset = 1'b0;
    step();
    chk("zero_an", anodos, 8'hFE);
    chk("zero_seg", segmentos, 7'h40);
    sweep(0);
    convert(16'd1234);
    sweep(shown);
    convert(16'h8000);
    sweep(shown);
    convert(16'hFFFB);
    sweep(shown);
    convert(16'd300);
    sweep(shown);
    producto = 16'd77;
    producto_valido = 1'b1;
    step();
    producto_valido = 1'b0;
    step();
    step();
    producto = 16'd99;
    producto_valido = 1'b1;
    step();
    producto_valido = 1'b0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      n += int'(listo);
    end
    chk("busy_listo_count", n, 1);
    shown = 77;
    sweep(shown);
    producto = 16'd1234;
    producto_valido = 1'b1;
    step();
    producto_valido = 1'b0;
    for (int c = 0; c < 7; c++) step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_ocupado", ocupado, 0);
    chk("midrst_listo", listo, 0);
    chk("midrst_an", anodos, 8'hFF);
    step();
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      n += int'(listo);
    end
    chk("midrst_no_listo", n, 0);
    shown = 0;
    sweep(shown);
    convert(16'd0);
    convert(16'd32767);
    sweep(shown);
    convert(16'hFFFF);
    sweep(shown);
    for (int r = 0; r < 20; r++) begin
      convert(16'($urandom));
      if ($urandom_range(0, 1) == 1) sweep(shown);
    end
    sweep(shown);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
